// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, tracks in-flight
// responses with a credit counter, and buffers returned words with their PCs
// in a small prefetch FIFO for decode. Redirects flush the FIFO and discard
// the responses that are still in flight.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a redirect
// to a misaligned target enters a FAULT state that raises a sticky fetch_fault
// and issues no requests. When it is undefined, the low two bits of the
// redirect target are ignored.
//
// Handshakes: a request transfers when mem_req_valid && mem_req_ready. An
// instruction transfers when ins_valid && ins_ready. A valid may be withdrawn
// only by a redirect. mem_rsp_valid has no back-pressure, because the credit
// counter guarantees FIFO space for every outstanding response.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_DRAIN = 2'd1, S_FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_DRAIN = 2'd1} state_t;
`endif

    state_t          state_q;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;       // PC of the next response that will be kept
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     fifo_pc_q   [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];

    logic            accept, push, pop, in_fault, can_issue;
    logic [CW:0]     credit_used;
    logic [31:0]     target_pc;

    assign target_pc = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign in_fault    = (state_q == S_FAULT);
    assign fetch_fault = fault_q;
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign in_fault       = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

    // Credits: every in-flight response (kept or discarded) plus every buffered word.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    assign can_issue     = credit_used < (CW + 1)'(DEPTH);
    assign mem_req_valid = !reset && can_issue && !redirect && !in_fault;
    assign mem_req_addr  = fetch_pc_q;

    assign ins_valid   = (count_q != '0);
    assign ins_data    = ins_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign ins_pc      = ins_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign dbg_state_o = state_q;

    assign accept = mem_req_valid && mem_req_ready;
    assign push   = mem_rsp_valid && !redirect && (discard_q == '0);
    assign pop    = ins_valid && ins_ready;

    // Next-state for the PC, credit, discard and FIFO pointer registers.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !mem_rsp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!accept && mem_rsp_valid) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        discard_d = discard_q;
        if (redirect) begin
            discard_d = outstanding_q - CW'(mem_rsp_valid);
        end else if (mem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (redirect) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)   rsp_pc_d   = rsp_pc_q + 32'd4;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage: write each kept response with the PC of its request.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
            fifo_data_q[wr_ptr_q] <= mem_rsp_data;
        end
    end

    // Control FSM: DRAIN while stale responses remain, FAULT after a misaligned redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect && misaligned) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
            end else if (redirect || (state_q != S_FAULT)) begin
                state_q <= (discard_d != '0) ? S_DRAIN : S_FETCH;
                fault_q <= 1'b0;
            end
`else
            state_q <= (discard_d != '0) ? S_DRAIN : S_FETCH;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model with fixed latency, plus a
// scoreboard that queues {pc, word} on every accepted request, drops the queue
// on redirect, and compares each instruction consumed by decode.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .ins_valid    (ins_valid),
        .ins_data     (ins_data),
        .ins_pc       (ins_pc),
        .ins_ready    (ins_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_fault  (fetch_fault),
        .dbg_state_o  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00a0_0113;
            32'h8:   return 32'h0020_81b3;
            32'hC:   return 32'h0020_f233;
            default: return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Scoreboard and memory model state
    logic [63:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_dlog[$];
    int          tick = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;

    // Memory drives responses on the falling edge; handshakes are sampled 1 time unit before the rising edge.
    always @(negedge clk) begin
        tick++;
        if (!reset && pend_addr.size() > 0 && pend_due[0] <= tick) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = imem(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
        #4;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            exp_q.delete();
            mem_rsp_valid = 1'b0;
        end else begin
            if (ins_valid && ins_ready) begin
                logic [63:0] e;
                check_eq("exp_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("ins_pc", ins_pc, e[63:32]);
                    check_eq("ins_data", ins_data, e[31:0]);
                end
                pop_log.push_back(ins_pc);
                pop_dlog.push_back(ins_data);
                pop_cnt++;
            end
            if (redirect) exp_q.delete();
            if (mem_req_valid && mem_req_ready) begin
                pend_addr.push_back(mem_req_addr);
                pend_due.push_back(tick + lat);
                exp_q.push_back({mem_req_addr, imem(mem_req_addr)});
                acc_log.push_back(mem_req_addr);
                acc_cnt++;
            end
        end
    end

    // Driver tasks
    task automatic do_reset(input int l, input logic rdy, input logic irdy);
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0;
        mem_req_ready = 1'b0;
        ins_ready = 1'b0;
        repeat (2) @(negedge clk);
        lat = l;
        acc_log.delete();
        pop_log.delete();
        pop_dlog.delete();
        acc_cnt = 0;
        pop_cnt = 0;
        mem_req_ready = rdy;
        ins_ready = irdy;
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int target;
        target = pop_cnt + n;
        for (int i = 0; i < 200 && pop_cnt < target; i++) @(negedge clk);
        check_eq("pop_timeout", 32'(pop_cnt >= target), 32'd1);
    endtask

    logic [31:0] exp_pcs [4];
    logic [31:0] exp_words [4];
    int          n_acc;

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        mem_req_ready = 1'b0;
        ins_ready = 1'b0;
        exp_pcs   = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_words = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3, 32'h0020_f233};

        // Outputs held at zero while in reset
        repeat (2) @(negedge clk);
        #4;
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_ins_valid", 32'(ins_valid), 32'd0);
        check_eq("rst_ins_data", ins_data, 32'h0);
        check_eq("rst_ins_pc", ins_pc, 32'h0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);

        // Zero-wait memory, decode always ready
        do_reset(1, 1'b1, 1'b1);
        #4;
        check_eq("first_req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("first_req_addr", mem_req_addr, RESET_PC);
        wait_pops(4);
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_pc", pop_log[i], exp_pcs[i]);
            check_eq("seq_data", pop_dlog[i], exp_words[i]);
        end

        // Decode stalled: credits cap requests at DEPTH
        do_reset(1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #4;
        check_eq("stall_acc", 32'(acc_cnt), 32'd4);
        check_eq("stall_req_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("one_more_acc", 32'(acc_cnt), 32'd5);
        check_eq("one_pop", 32'(pop_cnt), 32'd1);

        // Redirect with two responses in flight (latency 3)
        do_reset(3, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        mem_req_ready = 1'b1;
        check_eq("redir_acc", 32'(acc_cnt), 32'd2);
        wait_pops(2);
        check_eq("redir_pc0", pop_log[0], 32'h40);
        check_eq("redir_pc1", pop_log[1], 32'h44);

        // Memory not ready for 5 cycles: address held
        do_reset(1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #4;
            check_eq("hold_valid", 32'(mem_req_valid), 32'd1);
            check_eq("hold_addr", mem_req_addr, 32'h8);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        wait_pops(4);
        check_eq("resume_acc2", acc_log[2], 32'h8);
        check_eq("resume_acc3", acc_log[3], 32'hC);
        check_eq("resume_pop3", pop_log[3], 32'hC);

        // Misaligned redirect
        do_reset(1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        do_redirect(32'h42);
        pop_log.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        n_acc = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            #4;
            check_eq("fault_flag", 32'(fetch_fault), 32'd1);
            check_eq("fault_no_req", 32'(mem_req_valid), 32'd0);
            @(negedge clk);
        end
        check_eq("fault_acc", 32'(acc_cnt), 32'(n_acc));
        do_redirect(32'h80);
        #4;
        check_eq("fault_clear", 32'(fetch_fault), 32'd0);
        pop_log.delete();
        wait_pops(1);
        check_eq("fault_exit_pc", pop_log[0], 32'h80);
`else
        wait_pops(1);
        check_eq("align_pc", pop_log[0], 32'h40);
        check_eq("no_fault", 32'(fetch_fault), 32'd0);
`endif

        // fetch_pc wraps modulo 2^32
        do_reset(2, 1'b1, 1'b1);
        do_redirect(32'hFFFF_FFF8);
        pop_log.delete();
        wait_pops(3);
        check_eq("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
        check_eq("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
        check_eq("wrap_pc2", pop_log[2], 32'h0);

        // Asynchronous reset mid-operation
        do_reset(3, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        check_eq("pre_rst_ins_valid", 32'(ins_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("mid_rst_ins_valid", 32'(ins_valid), 32'd0);
        check_eq("mid_rst_ins_data", ins_data, 32'h0);
        check_eq("mid_rst_ins_pc", ins_pc, 32'h0);
        check_eq("mid_rst_fault", 32'(fetch_fault), 32'd0);
        do_reset(1, 1'b1, 1'b1);
        #4;
        check_eq("post_rst_addr", mem_req_addr, RESET_PC);
        check_eq("post_rst_valid", 32'(mem_req_valid), 32'd1);

        // Random back-pressure and aligned redirects
        do_reset(2, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            ins_ready     = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_pc   = 32'($urandom_range(0, 1023)) << 2;
        end
        @(negedge clk);
        redirect = 1'b0;
        mem_req_ready = 1'b0;
        ins_ready = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
        check_eq("rand_progress", 32'(pop_cnt > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
